// File: rtl/pmem_arbiter.sv
// pmem_arbiter
//   Shares the single 256-bit physical memory port between the I-cache line
//   fill interface and the D-cache fill/writeback interface. Only one
//   transaction is in flight at a time. The response is returned to the owner
//   in the same cycle that memory answers. When both caches contend, the one
//   that did not own the port last is granted, so the port alternates.
//
// State  | meaning
// -------+-----------------------------------------------------------------
// IDLE   | no owner; pmem_* held at 0, pmem_resp ignored, arbitration here
// GRANT_I| I-cache owns the port; pmem_* follow the i_* request
// GRANT_D| D-cache owns the port; pmem_* follow the d_* request
//
// Ports
//   clk, rst_n                   clock, synchronous active-low reset
//   i_read, i_addr               I-cache line read request (level)
//   i_resp, i_rdata              I-cache completion pulse and line data
//   d_read, d_write, d_addr,
//   d_wdata                      D-cache line read / writeback request (level)
//   d_resp, d_rdata              D-cache completion pulse and line data
//   pmem_read, pmem_write,
//   pmem_addr, pmem_wdata        memory command, held until pmem_resp
//   pmem_resp, pmem_rdata        memory completion pulse and read data
//   i_grants, d_grants,
//   conflicts                    saturating event counters
module pmem_arbiter #(
  parameter int CNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_read,
  input  logic [31:0]        i_addr,
  output logic               i_resp,
  output logic [255:0]       i_rdata,
  input  logic               d_read,
  input  logic               d_write,
  input  logic [31:0]        d_addr,
  input  logic [255:0]       d_wdata,
  output logic               d_resp,
  output logic [255:0]       d_rdata,
  output logic               pmem_read,
  output logic               pmem_write,
  output logic [31:0]        pmem_addr,
  output logic [255:0]       pmem_wdata,
  input  logic               pmem_resp,
  input  logic [255:0]       pmem_rdata,
  output logic [CNT_W-1:0]   i_grants,
  output logic [CNT_W-1:0]   d_grants,
  output logic [CNT_W-1:0]   conflicts
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t state;
  logic   last_d;  // 0: I owned the port last, 1: D owned it last
  logic   d_req;

  assign d_req = d_read | d_write;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      last_d    <= 1'b0;
      i_grants  <= '0;
      d_grants  <= '0;
      conflicts <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (i_read && d_req) begin
            // grant whoever did not own the port last
            state <= last_d ? GRANT_I : GRANT_D;
            if (conflicts != CNT_MAX) conflicts <= conflicts + CNT_ONE;
          end else if (i_read) begin
            state <= GRANT_I;
          end else if (d_req) begin
            state <= GRANT_D;
          end
        end
        GRANT_I: begin
          if (pmem_resp) begin
            state  <= IDLE;
            last_d <= 1'b0;
            if (i_grants != CNT_MAX) i_grants <= i_grants + CNT_ONE;
          end
        end
        GRANT_D: begin
          if (pmem_resp) begin
            state  <= IDLE;
            last_d <= 1'b1;
            if (d_grants != CNT_MAX) d_grants <= d_grants + CNT_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Command and response routing follow the owner combinationally so the
  // return path adds no latency.
  always_comb begin
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = '0;
    i_resp     = 1'b0;
    i_rdata    = '0;
    d_resp     = 1'b0;
    d_rdata    = '0;
    case (state)
      GRANT_I: begin
        pmem_read = i_read;
        pmem_addr = i_addr;
        if (pmem_resp) begin
          i_resp  = 1'b1;
          i_rdata = pmem_rdata;
        end
      end
      GRANT_D: begin
        pmem_read  = d_read;
        pmem_write = d_write;
        pmem_addr  = d_addr;
        pmem_wdata = d_wdata;
        if (pmem_resp) begin
          d_resp  = 1'b1;
          d_rdata = pmem_rdata;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
module tb_pmem_arbiter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_read;
  logic [31:0]  i_addr;
  logic         i_resp;
  logic [255:0] i_rdata;
  logic         d_read, d_write;
  logic [31:0]  d_addr;
  logic [255:0] d_wdata;
  logic         d_resp;
  logic [255:0] d_rdata;
  logic         pmem_read, pmem_write;
  logic [31:0]  pmem_addr;
  logic [255:0] pmem_wdata;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic [15:0]  i_grants, d_grants, conflicts;

  // narrow-counter instance for the saturation check; shares all inputs
  logic         s_i_resp, s_d_resp, s_pmem_read, s_pmem_write;
  logic [255:0] s_i_rdata, s_d_rdata, s_pmem_wdata;
  logic [31:0]  s_pmem_addr;
  logic [1:0]   s_i_grants, s_d_grants, s_conflicts;

  localparam logic [255:0] PAT = {8{32'hDEADBEEF}};
  localparam logic [255:0] WD  = {32{8'hA5}};

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  pmem_arbiter #(.CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_resp(i_resp), .i_rdata(i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(d_resp), .d_rdata(d_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .i_grants(i_grants), .d_grants(d_grants), .conflicts(conflicts)
  );

  pmem_arbiter #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_resp(s_i_resp), .i_rdata(s_i_rdata),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_resp(s_d_resp), .d_rdata(s_d_rdata),
    .pmem_read(s_pmem_read), .pmem_write(s_pmem_write), .pmem_addr(s_pmem_addr),
    .pmem_wdata(s_pmem_wdata), .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .i_grants(s_i_grants), .d_grants(s_d_grants), .conflicts(s_conflicts)
  );

  typedef struct {
    logic        i_rd;
    logic        d_rd;
    logic        d_wr;
    logic        p_rs;
    logic [31:0] ia;
    logic [31:0] da;
    logic        e_pr;
    logic        e_pw;
    logic [31:0] e_addr;
    logic        e_ir;
    logic        e_dr;
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, " pmem_read"}, 256'(pmem_read), 256'(0));
    check({tag, " pmem_write"}, 256'(pmem_write), 256'(0));
    check({tag, " pmem_addr"}, 256'(pmem_addr), 256'(0));
    check({tag, " i_resp"}, 256'(i_resp), 256'(0));
    check({tag, " d_resp"}, 256'(d_resp), 256'(0));
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // inputs change on the falling edge, outputs are compared 1 time unit later
  task automatic apply(input int lo, input int hi);
    for (int k = lo; k <= hi; k++) begin
      string t;
      @(negedge clk);
      i_read = vecs[k].i_rd; d_read = vecs[k].d_rd; d_write = vecs[k].d_wr;
      pmem_resp = vecs[k].p_rs; i_addr = vecs[k].ia; d_addr = vecs[k].da;
      #1;
      t = $sformatf("vec%0d", k);
      check({t, " pmem_read"}, 256'(pmem_read), 256'(vecs[k].e_pr));
      check({t, " pmem_write"}, 256'(pmem_write), 256'(vecs[k].e_pw));
      check({t, " pmem_addr"}, 256'(pmem_addr), 256'(vecs[k].e_addr));
      check({t, " pmem_wdata"}, pmem_wdata, vecs[k].e_pw ? WD : 256'(0));
      check({t, " i_resp"}, 256'(i_resp), 256'(vecs[k].e_ir));
      check({t, " d_resp"}, 256'(d_resp), 256'(vecs[k].e_dr));
      check({t, " i_rdata"}, i_rdata, vecs[k].e_ir ? PAT : 256'(0));
      check({t, " d_rdata"}, d_rdata, vecs[k].e_dr ? PAT : 256'(0));
    end
  endtask

  // one I-only transaction: IDLE cycle, grant cycle with immediate response
  task automatic i_txn();
    @(negedge clk); i_read = 1; pmem_resp = 0; i_addr = 32'h40;
    @(negedge clk); pmem_resp = 1;
    @(negedge clk); i_read = 0; pmem_resp = 0;
  endtask

  initial begin
    //        i  d  d  p  ia           da           pr pw addr         ir dr
    // lone I read of 0x60, memory answers 3 cycles after the request
    vecs[0] = '{1, 0, 0, 0, 32'h60, 32'h0, 0, 0, 32'h0,   0, 0};
    vecs[1] = '{1, 0, 0, 0, 32'h60, 32'h0, 1, 0, 32'h60,  0, 0};
    vecs[2] = '{1, 0, 0, 0, 32'h60, 32'h0, 1, 0, 32'h60,  0, 0};
    vecs[3] = '{1, 0, 0, 1, 32'h60, 32'h0, 1, 0, 32'h60,  1, 0};
    vecs[4] = '{0, 0, 0, 0, 32'h60, 32'h0, 0, 0, 32'h0,   0, 0};
    // simultaneous I read 0x100 and D write 0x200 after reset: D wins
    vecs[5] = '{1, 0, 1, 0, 32'h100, 32'h200, 0, 0, 32'h0,   0, 0};
    vecs[6] = '{1, 0, 1, 1, 32'h100, 32'h200, 0, 1, 32'h200, 0, 1};
    vecs[7] = '{1, 0, 0, 0, 32'h100, 32'h200, 0, 0, 32'h0,   0, 0};
    vecs[8] = '{1, 0, 0, 1, 32'h100, 32'h200, 1, 0, 32'h100, 1, 0};
    vecs[9] = '{0, 0, 0, 0, 32'h100, 32'h200, 0, 0, 32'h0,   0, 0};

    rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
    i_addr = 0; d_addr = 0; d_wdata = WD; pmem_rdata = PAT;

    // reset then idle, with a stray pmem_resp in IDLE
    do_reset();
    for (int c = 0; c < 5; c++) begin
      @(negedge clk); #1;
      check_idle_outputs($sformatf("idle%0d", c));
    end
    check("reset i_grants", 256'(i_grants), 256'(0));
    check("reset d_grants", 256'(d_grants), 256'(0));
    check("reset conflicts", 256'(conflicts), 256'(0));
    @(negedge clk); pmem_resp = 1; #1;
    check_idle_outputs("idle_resp");
    @(negedge clk); pmem_resp = 0;

    do_reset();
    apply(0, 4);
    check("lone i_grants", 256'(i_grants), 256'(1));
    check("lone d_grants", 256'(d_grants), 256'(0));

    do_reset();
    apply(5, 9);
    check("conf conflicts", 256'(conflicts), 256'(1));
    check("conf d_grants", 256'(d_grants), 256'(1));
    check("conf i_grants", 256'(i_grants), 256'(1));

    // both request continuously: grants alternate D,I,D,I,D,I
    do_reset();
    i_addr = 32'h100; d_addr = 32'h200;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk); i_read = 1; d_write = 1; pmem_resp = 0; #1;
      check_idle_outputs($sformatf("rr%0d idle", k));
      @(negedge clk); pmem_resp = 1; #1;
      check($sformatf("rr%0d d_resp", k), 256'(d_resp), 256'((k % 2) == 0));
      check($sformatf("rr%0d i_resp", k), 256'(i_resp), 256'((k % 2) == 1));
    end
    @(negedge clk); i_read = 0; d_write = 0; pmem_resp = 0; #1;
    check("rr conflicts", 256'(conflicts), 256'(6));
    check("rr d_grants", 256'(d_grants), 256'(3));
    check("rr i_grants", 256'(i_grants), 256'(3));

    // reset during GRANT_D abandons the owner
    do_reset();
    @(negedge clk); d_read = 1; d_addr = 32'h300;
    @(negedge clk); #1;
    check("mid pmem_read", 256'(pmem_read), 256'(1));
    check("mid pmem_addr", 256'(pmem_addr), 256'(32'h300));
    @(negedge clk); rst_n = 0; d_read = 0;
    @(negedge clk); rst_n = 1; pmem_resp = 1; #1;
    check_idle_outputs("mid after reset");
    check("mid d_grants", 256'(d_grants), 256'(0));
    // last must be I again: a conflict now goes to D
    @(negedge clk); pmem_resp = 0; i_read = 1; d_read = 1;
    @(negedge clk); pmem_resp = 1; #1;
    check("mid conflict d_resp", 256'(d_resp), 256'(1));
    check("mid conflict d_rdata", d_rdata, PAT);
    check("mid conflict i_resp", 256'(i_resp), 256'(0));
    @(negedge clk); pmem_resp = 0; i_read = 0; d_read = 0;
    // subsequent lone D read
    @(negedge clk); d_read = 1; d_addr = 32'h340;
    @(negedge clk); #1;
    check("lone d pmem_read", 256'(pmem_read), 256'(1));
    check("lone d pmem_addr", 256'(pmem_addr), 256'(32'h340));
    pmem_resp = 1; #1;
    check("lone d d_resp", 256'(d_resp), 256'(1));
    @(negedge clk); d_read = 0; pmem_resp = 0; #1;
    check("lone d d_grants", 256'(d_grants), 256'(2));

    // saturation of a 2-bit counter
    do_reset();
    for (int k = 0; k < 3; k++) i_txn();
    #1;
    check("sat after3", 256'(s_i_grants), 256'(3));
    for (int k = 0; k < 2; k++) i_txn();
    #1;
    check("sat after5", 256'(s_i_grants), 256'(3));
    check("wide after5", 256'(i_grants), 256'(5));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
